// File: rtl/cpu_sequencer.sv
// ============================================================================
// Module   : cpu_sequencer
// Purpose  : Registered one-hot control state machine for the accumulator CPU.
//            Sequences fetch, execute (ADD, AND, JMP, INC, JZ, LDAC, STAC,
//            HALT) and an illegal-opcode trap. Memory states hold until the
//            memory signals ready.
// Ports    : clk, rst_n (async, active-low)
//            OPCODE      - DR opcode field, looked at only in FETCH3
//            MEM_READY   - memory completes the current access
//            AC_ZERO     - accumulator is zero (used by JZ1)
//            ARLOAD/PCLOAD/DRLOAD/ACLOAD/IRLOAD/PCINC/ACINC - datapath strobes
//            ALUSEL      - 0 ADD, 1 AND, 2 PASS
//            SYSTEMBUSSEL- 0 PC, 1 DR, 2 MEM, 3 AC
//            MEM_REQ/MEMWRITE - memory access pending / access is a write
//            HALTED, ILLEGAL, RETIRE - status
//            STATE       - one-hot current state
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_sequencer #(
  parameter int OPCODE_W   = 4,
  parameter int NUM_STATES = 14
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [OPCODE_W-1:0]   OPCODE,
  input  logic                  MEM_READY,
  input  logic                  AC_ZERO,
  output logic                  ARLOAD,
  output logic                  PCLOAD,
  output logic                  DRLOAD,
  output logic                  ACLOAD,
  output logic                  IRLOAD,
  output logic                  PCINC,
  output logic                  ACINC,
  output logic [1:0]            ALUSEL,
  output logic [1:0]            SYSTEMBUSSEL,
  output logic                  MEM_REQ,
  output logic                  MEMWRITE,
  output logic                  HALTED,
  output logic                  ILLEGAL,
  output logic                  RETIRE,
  output logic [NUM_STATES-1:0] STATE
);

  // State values are the one-hot codes themselves, so the register drives
  // STATE directly and any non-one-hot value falls into the default arm.
  typedef enum logic [13:0] {
    S_FETCH1 = 14'h0001,
    S_FETCH2 = 14'h0002,
    S_FETCH3 = 14'h0004,
    S_ADD1   = 14'h0008,
    S_ADD2   = 14'h0010,
    S_AND1   = 14'h0020,
    S_AND2   = 14'h0040,
    S_JMP1   = 14'h0080,
    S_INC1   = 14'h0100,
    S_JZ1    = 14'h0200,
    S_LDAC1  = 14'h0400,
    S_LDAC2  = 14'h0800,
    S_STAC1  = 14'h1000,
    S_HALT1  = 14'h2000
  } state_t;

  localparam logic [1:0] BUS_PC  = 2'd0;
  localparam logic [1:0] BUS_DR  = 2'd1;
  localparam logic [1:0] BUS_MEM = 2'd2;
  localparam logic [1:0] BUS_AC  = 2'd3;

  localparam logic [1:0] ALU_ADD  = 2'd0;
  localparam logic [1:0] ALU_AND  = 2'd1;
  localparam logic [1:0] ALU_PASS = 2'd2;

  state_t state_q, state_d;
  // Set once HALT1 has been occupied for a cycle; limits RETIRE to entry.
  logic   halt_seen_q;
  logic   illegal_op;

  assign illegal_op = (OPCODE > OPCODE_W'(7));
  assign STATE      = NUM_STATES'(state_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_FETCH1;
      halt_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      halt_seen_q <= (state_q == S_HALT1);
    end
  end

  always_comb begin
    state_d      = S_FETCH1;
    ARLOAD       = 1'b0;
    PCLOAD       = 1'b0;
    DRLOAD       = 1'b0;
    ACLOAD       = 1'b0;
    IRLOAD       = 1'b0;
    PCINC        = 1'b0;
    ACINC        = 1'b0;
    ALUSEL       = ALU_ADD;
    SYSTEMBUSSEL = BUS_PC;
    MEM_REQ      = 1'b0;
    MEMWRITE     = 1'b0;
    HALTED       = 1'b0;
    ILLEGAL      = 1'b0;
    RETIRE       = 1'b0;

    case (state_q)
      S_FETCH1: begin
        ARLOAD  = 1'b1;
        state_d = S_FETCH2;
      end
      S_FETCH2: begin
        MEM_REQ      = 1'b1;
        SYSTEMBUSSEL = BUS_MEM;
        DRLOAD       = MEM_READY;
        PCINC        = MEM_READY;
        state_d      = MEM_READY ? S_FETCH3 : S_FETCH2;
      end
      S_FETCH3: begin
        ARLOAD       = 1'b1;
        IRLOAD       = 1'b1;
        SYSTEMBUSSEL = BUS_DR;
        if (illegal_op) begin
          // Trap: retire as a NOP and refetch.
          ILLEGAL = 1'b1;
          RETIRE  = 1'b1;
          state_d = S_FETCH1;
        end else begin
          case (OPCODE[2:0])
            3'd0:    state_d = S_ADD1;
            3'd1:    state_d = S_AND1;
            3'd2:    state_d = S_JMP1;
            3'd3:    state_d = S_INC1;
            3'd4:    state_d = S_JZ1;
            3'd5:    state_d = S_LDAC1;
            3'd6:    state_d = S_STAC1;
            default: state_d = S_HALT1;
          endcase
        end
      end
      S_ADD1: begin
        MEM_REQ      = 1'b1;
        SYSTEMBUSSEL = BUS_MEM;
        DRLOAD       = MEM_READY;
        state_d      = MEM_READY ? S_ADD2 : S_ADD1;
      end
      S_AND1: begin
        MEM_REQ      = 1'b1;
        SYSTEMBUSSEL = BUS_MEM;
        DRLOAD       = MEM_READY;
        state_d      = MEM_READY ? S_AND2 : S_AND1;
      end
      S_LDAC1: begin
        MEM_REQ      = 1'b1;
        SYSTEMBUSSEL = BUS_MEM;
        DRLOAD       = MEM_READY;
        state_d      = MEM_READY ? S_LDAC2 : S_LDAC1;
      end
      S_ADD2: begin
        ACLOAD       = 1'b1;
        SYSTEMBUSSEL = BUS_DR;
        ALUSEL       = ALU_ADD;
        RETIRE       = 1'b1;
      end
      S_AND2: begin
        ACLOAD       = 1'b1;
        SYSTEMBUSSEL = BUS_DR;
        ALUSEL       = ALU_AND;
        RETIRE       = 1'b1;
      end
      S_LDAC2: begin
        ACLOAD       = 1'b1;
        SYSTEMBUSSEL = BUS_DR;
        ALUSEL       = ALU_PASS;
        RETIRE       = 1'b1;
      end
      S_JMP1: begin
        PCLOAD       = 1'b1;
        SYSTEMBUSSEL = BUS_DR;
        RETIRE       = 1'b1;
      end
      S_INC1: begin
        ACINC  = 1'b1;
        RETIRE = 1'b1;
      end
      S_JZ1: begin
        SYSTEMBUSSEL = BUS_DR;
        PCLOAD       = AC_ZERO;
        RETIRE       = 1'b1;
      end
      S_STAC1: begin
        MEM_REQ      = 1'b1;
        MEMWRITE     = 1'b1;
        SYSTEMBUSSEL = BUS_AC;
        RETIRE       = MEM_READY;
        state_d      = MEM_READY ? S_FETCH1 : S_STAC1;
      end
      S_HALT1: begin
        HALTED  = 1'b1;
        RETIRE  = ~halt_seen_q;
        state_d = S_HALT1;
      end
      default: begin
        // Corrupted encoding: all strobes stay at their zero defaults and
        // the machine re-enters FETCH1.
        state_d = S_FETCH1;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_cpu_sequencer.sv
// ============================================================================
// Module   : tb_cpu_sequencer
// Purpose  : Self-checking bench for cpu_sequencer. Each instruction is
//            described by opcode, fetch/execute wait counts and AC_ZERO; the
//            bench derives the expected state walk, per-cycle handshake
//            outputs and per-instruction strobe totals from those parameters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cpu_sequencer;

  logic        clk;
  logic        rst_n;
  logic [3:0]  OPCODE;
  logic        MEM_READY;
  logic        AC_ZERO;
  logic        ARLOAD, PCLOAD, DRLOAD, ACLOAD, IRLOAD, PCINC, ACINC;
  logic [1:0]  ALUSEL;
  logic [1:0]  SYSTEMBUSSEL;
  logic        MEM_REQ, MEMWRITE, HALTED, ILLEGAL, RETIRE;
  logic [13:0] STATE;

  int checks = 0;
  int errors = 0;

  cpu_sequencer #(.OPCODE_W(4), .NUM_STATES(14)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .OPCODE       (OPCODE),
    .MEM_READY    (MEM_READY),
    .AC_ZERO      (AC_ZERO),
    .ARLOAD       (ARLOAD),
    .PCLOAD       (PCLOAD),
    .DRLOAD       (DRLOAD),
    .ACLOAD       (ACLOAD),
    .IRLOAD       (IRLOAD),
    .PCINC        (PCINC),
    .ACINC        (ACINC),
    .ALUSEL       (ALUSEL),
    .SYSTEMBUSSEL (SYSTEMBUSSEL),
    .MEM_REQ      (MEM_REQ),
    .MEMWRITE     (MEMWRITE),
    .HALTED       (HALTED),
    .ILLEGAL      (ILLEGAL),
    .RETIRE       (RETIRE),
    .STATE        (STATE)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_state"}, 32'(STATE), 32'd1);
    chk({tag, "_arload"}, 32'(ARLOAD), 32'd1);
    chk({tag, "_others"},
        32'({PCLOAD, DRLOAD, ACLOAD, IRLOAD, PCINC, ACINC, ALUSEL, SYSTEMBUSSEL,
             MEM_REQ, MEMWRITE, HALTED, ILLEGAL, RETIRE}), 32'd0);
  endtask

  // Called at least 1 time unit after a rising edge; returns just after the
  // next rising edge with reset released and the core in FETCH1.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Runs one instruction starting in FETCH1. wf/we are MEM_READY=0 cycles in
  // FETCH2 / the execute memory state, hold is extra HALT1 cycles, and abort
  // (>=0) drops rst_n after sampling that cycle.
  task automatic run_instr(input int op, input int wf, input int we,
                           input bit acz, input int hold, input int abort);
    int   exp_st[$];
    bit   legal, mem_rd, mem_op;
    int   fr, e0, er, ret_idx, ncyc;
    int   n_dr, n_pcinc, n_ir, n_ar, n_ac, n_acinc, n_pcl, n_ill, n_ret, n_bus3;
    logic [13:0] exp_state;
    string nm;

    legal  = (op < 8);
    mem_rd = (op == 0) || (op == 1) || (op == 5);
    mem_op = mem_rd || (op == 6);
    nm     = $sformatf("op%0d_wf%0d_we%0d", op, wf, we);

    exp_st.push_back(0);
    repeat (wf + 1) exp_st.push_back(1);
    exp_st.push_back(2);
    if (legal) begin
      case (op)
        0: begin repeat (we + 1) exp_st.push_back(3);  exp_st.push_back(4);  end
        1: begin repeat (we + 1) exp_st.push_back(5);  exp_st.push_back(6);  end
        2: exp_st.push_back(7);
        3: exp_st.push_back(8);
        4: exp_st.push_back(9);
        5: begin repeat (we + 1) exp_st.push_back(10); exp_st.push_back(11); end
        6: repeat (we + 1) exp_st.push_back(12);
        default: repeat (hold + 1) exp_st.push_back(13);
      endcase
    end
    ncyc    = exp_st.size();
    fr      = wf + 1;
    e0      = wf + 3;
    er      = e0 + we;
    ret_idx = (op == 7) ? e0 : ncyc - 1;

    n_dr = 0; n_pcinc = 0; n_ir = 0; n_ar = 0; n_ac = 0;
    n_acinc = 0; n_pcl = 0; n_ill = 0; n_ret = 0; n_bus3 = 0;

    for (int c = 0; c < ncyc; c++) begin
      OPCODE    = 4'($urandom);
      MEM_READY = 1'($urandom);
      AC_ZERO   = 1'($urandom);
      if (c >= 1 && c <= fr) MEM_READY = (c == fr);
      if (c == wf + 2) OPCODE = 4'(op);
      if (mem_op && c >= e0 && c <= er) MEM_READY = (c == er);
      if (op == 4 && c == e0) AC_ZERO = acz;

      @(negedge clk);
      exp_state = 14'd1 << exp_st[c];
      chk({nm, "_state"}, 32'(STATE), 32'(exp_state));
      chk({nm, "_retire"}, 32'(RETIRE), 32'(c == ret_idx));
      chk({nm, "_memreq"}, 32'(MEM_REQ),
          32'((c >= 1 && c <= fr) || (mem_op && c >= e0 && c <= er)));
      chk({nm, "_memwrite"}, 32'(MEMWRITE), 32'(op == 6 && c >= e0 && c <= er));
      chk({nm, "_halted"}, 32'(HALTED), 32'(op == 7 && c >= e0));
      if (mem_rd && c == ncyc - 1) begin
        chk({nm, "_alusel"}, 32'(ALUSEL), (op == 0) ? 32'd0 : (op == 1) ? 32'd1 : 32'd2);
        chk({nm, "_bus_dr"}, 32'(SYSTEMBUSSEL), 32'd1);
      end

      n_dr    += int'(DRLOAD);
      n_pcinc += int'(PCINC);
      n_ir    += int'(IRLOAD);
      n_ar    += int'(ARLOAD);
      n_ac    += int'(ACLOAD);
      n_acinc += int'(ACINC);
      n_pcl   += int'(PCLOAD);
      n_ill   += int'(ILLEGAL);
      n_ret   += int'(RETIRE);
      n_bus3  += int'(SYSTEMBUSSEL == 2'd3);

      if (c == abort) begin
        rst_n = 1'b0;
        #1;
        chk({nm, "_abort"}, 32'(STATE), 32'd1);
        chk({nm, "_abort_arload"}, 32'(ARLOAD), 32'd1);
        chk({nm, "_abort_retire"}, 32'(RETIRE), 32'd0);
        chk({nm, "_abort_memreq"}, 32'(MEM_REQ), 32'd0);
        return;
      end
      @(posedge clk);
      #1;
    end

    chk({nm, "_n_drload"}, 32'(n_dr), 32'(1 + int'(mem_rd)));
    chk({nm, "_n_pcinc"}, 32'(n_pcinc), 32'd1);
    chk({nm, "_n_irload"}, 32'(n_ir), 32'd1);
    chk({nm, "_n_arload"}, 32'(n_ar), 32'd2);
    chk({nm, "_n_acload"}, 32'(n_ac), 32'(mem_rd));
    chk({nm, "_n_acinc"}, 32'(n_acinc), 32'(op == 3));
    chk({nm, "_n_pcload"}, 32'(n_pcl), 32'((op == 2) || (op == 4 && acz)));
    chk({nm, "_n_illegal"}, 32'(n_ill), 32'(!legal));
    chk({nm, "_n_retire"}, 32'(n_ret), 32'd1);
    chk({nm, "_n_bus_ac"}, 32'(n_bus3), (op == 6) ? 32'(we + 1) : 32'd0);
  endtask

  initial begin
    int op;
    rst_n     = 1'b1;
    OPCODE    = 4'd0;
    MEM_READY = 1'b0;
    AC_ZERO   = 1'b0;
    #2;
    do_reset();

    // ADD, no waits: 5 cycles.
    run_instr(0, 0, 0, 1'b0, 0, -1);
    // LDAC with 2 fetch waits and 3 execute waits: 10 cycles.
    run_instr(5, 2, 3, 1'b0, 0, -1);
    // JZ taken and not taken.
    run_instr(4, 0, 0, 1'b1, 0, -1);
    run_instr(4, 0, 0, 1'b0, 0, -1);
    // STAC with one wait cycle.
    run_instr(6, 0, 1, 1'b0, 0, -1);
    // Illegal opcode 9, then other simple ops.
    run_instr(9, 0, 0, 1'b0, 0, -1);
    run_instr(2, 1, 0, 1'b0, 0, -1);
    run_instr(3, 0, 0, 1'b0, 0, -1);
    run_instr(1, 0, 2, 1'b0, 0, -1);

    // Randomized instruction mix.
    for (int i = 0; i < 60; i++) begin
      op = int'($urandom_range(0, 15));
      if (op == 7) op = 3;
      run_instr(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                1'($urandom), 0, -1);
    end

    // Reset during an ADD1 wait state, then a normal instruction.
    run_instr(0, 0, 3, 1'b0, 0, 4);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_instr(3, 0, 0, 1'b0, 0, -1);

    // Halt for 22 extra cycles, then reset and resume.
    run_instr(7, 1, 0, 1'b0, 22, -1);
    do_reset();
    run_instr(0, 1, 1, 1'b0, 0, -1);
    #1;
    chk("final_state", 32'(STATE), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
